row_scan_sequencer: RTL and testbench

//  Generates the 3-bit row index and enable that drive the 3-to-8 row decoder in the display/keypad scan path.

---
 rtl/scan_pkg.sv | 11 +
 rtl/scan_next_row.sv | 28 ++
 rtl/row_scan_sequencer.sv | 171 +++++++++++++++++
 tb/tb_row_scan_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the row scan path: FSM state encoding and row geometry.
package scan_pkg;
  localparam int ROWS  = 8;
  localparam int ROW_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DWELL = 2'd2
  } state_t;
endpackage

// File: rtl/scan_next_row.sv
// Circular search for the first enabled row strictly above i_cur (wraps 7->0).
// With only i_cur enabled the search lands on i_cur itself, which reports as a wrap.
module scan_next_row
  import scan_pkg::*;
(
  input  logic [ROWS-1:0]  i_mask,
  input  logic [ROW_W-1:0] i_cur,
  output logic [ROW_W-1:0] o_next,
  output logic             o_wrap,
  output logic             o_none
);

  logic [ROW_W-1:0] w_idx;

  // Walk from the farthest offset down so the nearest enabled row wins.
  always_comb begin
    o_next = i_cur;
    w_idx  = i_cur;
    for (int k = ROWS; k >= 1; k--) begin
      w_idx = i_cur + ROW_W'(k);
      if (i_mask[w_idx]) o_next = w_idx;
    end
  end

  assign o_wrap = (o_next <= i_cur);
  assign o_none = (i_mask == '0);

endmodule

// File: rtl/row_scan_sequencer.sv
// Drives row index and enable of a 3-to-8 row decoder: circular scan of enabled rows with
// dead time before every row, a programmable dwell per row and a pulse per completed frame.
//   state    | meaning
//   ST_IDLE  | decoder off, waiting for start with a non-empty mask
//   ST_BLANK | sel already on the new row, decoder held off for BLANK_CYC cycles
//   ST_DWELL | decoder on for max(dwell,1) cycles, sel frozen
module row_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DW         = 8,
  parameter int BLANK_CYC  = 2,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [ROWS-1:0]  i_row_mask,
  input  logic [DW-1:0]    i_dwell,
  output logic [ROW_W-1:0] o_sel,
  output logic             o_dec_en,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_sel, w_sel_nxt;
  logic [ROWS-1:0]  r_mask_lat, w_mask_nxt;
  logic [DW-1:0]    r_dwell_lat, w_dwell_lat_nxt;
  logic [DW-1:0]    r_dwell_cnt, w_dwell_cnt_nxt;
  logic [BW-1:0]    r_blank_cnt, w_blank_nxt;
  logic             r_stop_pend, w_stop_pend_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_dec_en, r_busy;
  logic             w_go_row, w_relatch, w_end_frame;
  logic [ROW_W-1:0] w_next_row;

  logic [ROW_W-1:0] w_first_row, w_cur_next;
  logic             w_first_wrap, w_first_none, w_first_ok;
  logic             w_cur_wrap, w_cur_none;

  // Searching from row 7 yields the lowest set bit of the incoming mask.
  scan_next_row u_first (
    .i_mask (i_row_mask),
    .i_cur  (ROW_W'(ROWS - 1)),
    .o_next (w_first_row),
    .o_wrap (w_first_wrap),
    .o_none (w_first_none)
  );

  scan_next_row u_cur (
    .i_mask (r_mask_lat),
    .i_cur  (r_sel),
    .o_next (w_cur_next),
    .o_wrap (w_cur_wrap),
    .o_none (w_cur_none)
  );

  assign w_first_ok = w_first_wrap && !w_first_none;

  function automatic logic [DW-1:0] dwell_load(input logic [DW-1:0] d);
    return (d == '0) ? '0 : d - DW'(1);
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_mask_nxt       = r_mask_lat;
    w_dwell_lat_nxt  = r_dwell_lat;
    w_dwell_cnt_nxt  = r_dwell_cnt;
    w_blank_nxt      = r_blank_cnt;
    w_stop_pend_nxt  = r_stop_pend;
    w_frame_done_nxt = 1'b0;
    w_go_row         = 1'b0;
    w_relatch        = 1'b0;
    w_end_frame      = 1'b0;
    w_next_row       = r_sel;

    case (r_state)
      ST_IDLE: begin
        w_stop_pend_nxt = 1'b0;
        if (i_start && !i_stop && w_first_ok) begin
          w_mask_nxt      = i_row_mask;
          w_dwell_lat_nxt = i_dwell;
          w_sel_nxt       = w_first_row;
          w_relatch       = 1'b1;
          w_go_row        = 1'b1;
        end
      end
      ST_BLANK: begin
        if (i_stop) w_stop_pend_nxt = 1'b1;
        if (r_blank_cnt == '0) begin
          w_state_nxt     = ST_DWELL;
          w_dwell_cnt_nxt = dwell_load(r_dwell_lat);
        end else begin
          w_blank_nxt = r_blank_cnt - BW'(1);
        end
      end
      ST_DWELL: begin
        if (i_stop) w_stop_pend_nxt = 1'b1;
        if (r_dwell_cnt != '0) begin
          w_dwell_cnt_nxt = r_dwell_cnt - DW'(1);
        end else begin
          w_next_row = w_cur_next;
          if (w_cur_wrap || w_cur_none) begin
            w_frame_done_nxt = 1'b1;
            w_mask_nxt       = i_row_mask;
            w_dwell_lat_nxt  = i_dwell;
            w_relatch        = 1'b1;
            w_next_row       = w_first_row;
            if (!w_first_ok || !CONTINUOUS) w_end_frame = 1'b1;
          end
          if (w_end_frame || r_stop_pend || i_stop) begin
            w_state_nxt     = ST_IDLE;
            w_stop_pend_nxt = 1'b0;
          end else begin
            w_sel_nxt = w_next_row;
            w_go_row  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A freshly latched dwell is not in r_dwell_lat yet when blanking is disabled.
    if (w_go_row) begin
      if (BLANK_CYC == 0) begin
        w_state_nxt     = ST_DWELL;
        w_dwell_cnt_nxt = dwell_load(w_relatch ? i_dwell : r_dwell_lat);
      end else begin
        w_state_nxt = ST_BLANK;
        w_blank_nxt = BLANK_LOAD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_mask_lat   <= '0;
      r_dwell_lat  <= '0;
      r_dwell_cnt  <= '0;
      r_blank_cnt  <= '0;
      r_stop_pend  <= 1'b0;
      r_frame_done <= 1'b0;
      r_dec_en     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_mask_lat   <= w_mask_nxt;
      r_dwell_lat  <= w_dwell_lat_nxt;
      r_dwell_cnt  <= w_dwell_cnt_nxt;
      r_blank_cnt  <= w_blank_nxt;
      r_stop_pend  <= w_stop_pend_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_dec_en     <= (w_state_nxt == ST_DWELL);
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_sel        = r_sel;
  assign o_dec_en     = r_dec_en;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer: continuous-frame instance plus a single-frame instance.
module tb_row_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [7:0] row_mask = 8'h00, dwell = 8'h00;
  logic [2:0] sel;
  logic       dec_en, busy, frame_done;

  logic       rst2 = 1'b1, start2 = 1'b0, stop2 = 1'b0;
  logic [7:0] row_mask2 = 8'h00, dwell2 = 8'h00;
  logic [2:0] sel2;
  logic       dec_en2, busy2, frame_done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] dec_oh, dec_oh2;
  assign dec_oh  = dec_en  ? (8'd1 << sel)  : 8'd0;
  assign dec_oh2 = dec_en2 ? (8'd1 << sel2) : 8'd0;

  row_scan_sequencer #(.DW(8), .BLANK_CYC(2), .CONTINUOUS(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_row_mask(row_mask), .i_dwell(dwell),
    .o_sel(sel), .o_dec_en(dec_en), .o_busy(busy), .o_frame_done(frame_done)
  );

  row_scan_sequencer #(.DW(8), .BLANK_CYC(2), .CONTINUOUS(1'b0)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_stop(stop2),
    .i_row_mask(row_mask2), .i_dwell(dwell2),
    .o_sel(sel2), .o_dec_en(dec_en2), .o_busy(busy2), .o_frame_done(frame_done2)
  );

  // Rows the current test may legally enable; sel must not move while the decoder is on.
  logic [7:0] mon_mask = 8'hFF;
  logic       mon_prev_en = 1'b0;
  logic [2:0] mon_prev_sel = 3'd0;

  always @(negedge clk) begin
    if (rst) begin
      mon_prev_en <= 1'b0;
    end else begin
      if (dec_en) begin
        n_checks++;
        if (mon_mask[sel] !== 1'b1 || (mon_prev_en && sel !== mon_prev_sel)) begin
          n_fail++;
          $display("FAIL monitor_dec_en: sel=%0d prev_en=%b prev_sel=%0d, need sel in mask %h and stable",
                   sel, mon_prev_en, mon_prev_sel, mon_mask);
        end
      end
      mon_prev_en  <= dec_en;
      mon_prev_sel <= sel;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 3ms");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rst2 = 1'b1;
    start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    tick();
    tick();
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; row_mask = 8'hFF; dwell = 8'd3; start = 1'b1;
    tick();
    tick();
    n_checks++;
    if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d need 0", sel); end
    n_checks++;
    if (dec_en !== 1'b0) begin n_fail++; $display("FAIL reset_dec_en: got %b need 0", dec_en); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b need 0", frame_done); end
    start = 1'b0; rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after: busy got %b need 0", busy); end
  endtask

  task automatic test_full_scan();
    logic [2:0] e_sel; logic e_en, e_fd; logic [7:0] e_oh;
    do_reset();
    mon_mask = 8'hFF; row_mask = 8'hFF; dwell = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 85; k++) begin
      e_sel = 3'((k / 5) % 8);
      e_en  = ((k % 5) >= 2);
      e_fd  = (k > 0) && (k % 40 == 0);
      e_oh  = e_en ? (8'd1 << e_sel) : 8'd0;
      n_checks++;
      if ({sel, dec_en, busy, frame_done, dec_oh} !== {e_sel, e_en, 1'b1, e_fd, e_oh}) begin
        n_fail++;
        $display("FAIL full_scan k=%0d: got sel=%0d en=%b busy=%b fd=%b oh=%h need sel=%0d en=%b busy=1 fd=%b oh=%h",
                 k, sel, dec_en, busy, frame_done, dec_oh, e_sel, e_en, e_fd, e_oh);
      end
      tick();
    end
  endtask

  task automatic test_sparse_mask();
    logic [2:0] e_sel; logic e_en, e_fd; logic [7:0] e_oh; int j;
    do_reset();
    mon_mask = 8'b1010_0100; row_mask = 8'b1010_0100; dwell = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 28; k++) begin
      j     = (k / 3) % 3;
      e_sel = (j == 0) ? 3'd2 : (j == 1) ? 3'd5 : 3'd7;
      e_en  = (k % 3 == 2);
      e_fd  = (k > 0) && (k % 9 == 0);
      e_oh  = e_en ? (8'd1 << e_sel) : 8'd0;
      n_checks++;
      if ({sel, dec_en, busy, frame_done, dec_oh} !== {e_sel, e_en, 1'b1, e_fd, e_oh}) begin
        n_fail++;
        $display("FAIL sparse_mask k=%0d: got sel=%0d en=%b busy=%b fd=%b need sel=%0d en=%b busy=1 fd=%b",
                 k, sel, dec_en, busy, frame_done, e_sel, e_en, e_fd);
      end
      tick();
    end
  endtask

  task automatic test_single_row();
    logic e_en, e_fd;
    do_reset();
    mon_mask = 8'h10; row_mask = 8'h10; dwell = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e_en = (k % 3 == 2);
      e_fd = (k > 0) && (k % 3 == 0);
      n_checks++;
      if ({sel, dec_en, busy, frame_done} !== {3'd4, e_en, 1'b1, e_fd}) begin
        n_fail++;
        $display("FAIL single_row k=%0d: got sel=%0d en=%b busy=%b fd=%b need sel=4 en=%b busy=1 fd=%b",
                 k, sel, dec_en, busy, frame_done, e_en, e_fd);
      end
      tick();
    end
  endtask

  task automatic test_stop();
    logic [2:0] e_sel; logic e_en, e_busy;
    do_reset();
    mon_mask = 8'hFF; row_mask = 8'hFF; dwell = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 36; k++) begin
      e_sel  = (k <= 27) ? 3'(k / 7) : 3'd3;
      e_en   = (k <= 27) && ((k % 7) >= 2);
      e_busy = (k <= 27);
      n_checks++;
      if ({sel, dec_en, busy, frame_done} !== {e_sel, e_en, e_busy, 1'b0}) begin
        n_fail++;
        $display("FAIL stop_mid_dwell k=%0d: got sel=%0d en=%b busy=%b fd=%b need sel=%0d en=%b busy=%b fd=0",
                 k, sel, dec_en, busy, frame_done, e_sel, e_en, e_busy);
      end
      stop = (k == 24);
      tick();
    end
    stop = 1'b0;
    row_mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if ({busy, dec_en, sel} !== {1'b0, 1'b0, 3'd3}) begin
      n_fail++;
      $display("FAIL start_empty_mask: got busy=%b en=%b sel=%0d need busy=0 en=0 sel=3", busy, dec_en, sel);
    end
    row_mask = 8'hFF; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    n_checks++;
    if ({busy, dec_en, sel} !== {1'b0, 1'b0, 3'd3}) begin
      n_fail++;
      $display("FAIL start_with_stop: got busy=%b en=%b sel=%0d need busy=0 en=0 sel=3", busy, dec_en, sel);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, dec_en, sel} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL restart_after_stop: got busy=%b en=%b sel=%0d need busy=1 en=0 sel=0", busy, dec_en, sel);
    end
  endtask

  task automatic test_mask_change();
    logic [2:0] e_sel; logic e_en, e_busy, e_fd; int j;
    do_reset();
    mon_mask = 8'hFF; row_mask = 8'hFF; dwell = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < 24) begin
        e_sel = 3'(k / 3); e_en = (k % 3 == 2); e_busy = 1'b1; e_fd = 1'b0;
      end else if (k < 36) begin
        j = k - 24;
        e_sel = 3'((j / 3) % 2); e_en = (j % 3 == 2); e_busy = 1'b1; e_fd = (j % 6 == 0);
      end else begin
        e_sel = 3'd1; e_en = 1'b0; e_busy = 1'b0; e_fd = (k == 36);
      end
      n_checks++;
      if ({sel, dec_en, busy, frame_done} !== {e_sel, e_en, e_busy, e_fd}) begin
        n_fail++;
        $display("FAIL mask_change k=%0d: got sel=%0d en=%b busy=%b fd=%b need sel=%0d en=%b busy=%b fd=%b",
                 k, sel, dec_en, busy, frame_done, e_sel, e_en, e_busy, e_fd);
      end
      if (k == 5)  row_mask = 8'h03;
      if (k == 31) row_mask = 8'h00;
      tick();
    end
  endtask

  task automatic test_single_frame();
    logic [2:0] e_sel; logic e_en, e_busy, e_fd;
    do_reset();
    row_mask2 = 8'h81; dwell2 = 8'd2; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      e_sel  = (k < 4) ? 3'd0 : 3'd7;
      e_en   = (k < 8) && ((k % 4) >= 2);
      e_busy = (k < 8);
      e_fd   = (k == 8);
      n_checks++;
      if ({sel2, dec_en2, busy2, frame_done2, dec_oh2} !==
          {e_sel, e_en, e_busy, e_fd, (e_en ? (8'd1 << e_sel) : 8'd0)}) begin
        n_fail++;
        $display("FAIL single_frame k=%0d: got sel=%0d en=%b busy=%b fd=%b need sel=%0d en=%b busy=%b fd=%b",
                 k, sel2, dec_en2, busy2, frame_done2, e_sel, e_en, e_busy, e_fd);
      end
      tick();
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({dec_en2, sel2} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL pre_rst_dwell: got en=%b sel=%0d need en=1 sel=0", dec_en2, sel2);
    end
    rst2 = 1'b1;
    tick();
    n_checks++;
    if ({sel2, dec_en2, busy2, frame_done2} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL rst_mid_dwell: got sel=%0d en=%b busy=%b fd=%b need all 0", sel2, dec_en2, busy2, frame_done2);
    end
    rst2 = 1'b0;
    tick();
    n_checks++;
    if ({busy2, frame_done2, dec_en2} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_rst_quiet: got busy=%b fd=%b en=%b need 0 0 0", busy2, frame_done2, dec_en2);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_single_row();
    test_stop();
    test_mask_change();
    test_single_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
